// File: rtl/pos_cell_reader.sv
`default_nettype none
// pos_cell_reader: reads a particle count from cell RAM address 0, then streams words 1..count
// through a 4-entry FIFO with valid/ready handshake. Optional macro: CELL_READER_CLAMP_EN.
module pos_cell_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rd_address,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  busy,
  output logic                  done,
  output logic                  count_ovf
);

  localparam int PW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_CNT   = 3'd1,
    WAIT_CNT = 3'd2,
    STREAM   = 3'd3,
    FINISH   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [PW-1:0]         r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_count;
  logic                  r_ovf;

  // Read-return pipeline: tracks the two cycles of RAM latency
  logic                  r_vld_d1;
  logic                  r_vld_d2;
  logic [ADDR_WIDTH-1:0] r_pid_d1;
  logic [ADDR_WIDTH-1:0] r_pid_d2;

  logic [DATA_WIDTH-1:0] r_fifo_data [0:3];
  logic [ADDR_WIDTH-1:0] r_fifo_pid  [0:3];
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_head;
  logic [2:0]            r_occ;

  logic [ADDR_WIDTH-1:0] w_cnt_raw;
  logic [ADDR_WIDTH-1:0] w_cnt;
  logic                  w_cnt_ovf;
  logic                  w_cnt_sample;
  logic [1:0]            w_inflight;
  logic [2:0]            w_budget;
  logic                  w_all_issued;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_stream_end;

  assign w_cnt_raw = rd_q[ADDR_WIDTH-1:0];

`ifdef CELL_READER_CLAMP_EN
  localparam logic [ADDR_WIDTH-1:0] C_CNT_MAX = ADDR_WIDTH'(PARTICLE_NUM - 1);
  assign w_cnt_ovf = (w_cnt_raw > C_CNT_MAX);
  assign w_cnt     = w_cnt_ovf ? C_CNT_MAX : w_cnt_raw;
`else
  assign w_cnt_ovf = 1'b0;
  assign w_cnt     = w_cnt_raw;
`endif

  assign w_cnt_sample = (r_state == WAIT_CNT) && r_vld_d2;
  assign w_inflight   = {1'b0, r_vld_d1} + {1'b0, r_vld_d2};
  // Budget ignores a same-cycle pop, so the FIFO can never be overrun
  assign w_budget     = r_occ + {1'b0, w_inflight};
  assign w_all_issued = (r_rd_ptr > {1'b0, r_count});
  assign w_issue      = (r_state == STREAM) && !w_all_issued && (w_budget < 3'd4);
  assign w_push       = (r_state == STREAM) && r_vld_d2;
  assign w_pop        = out_valid && out_ready;
  // Leave STREAM on the edge that drains the final entry
  assign w_stream_end = w_all_issued && !r_vld_d1 && !r_vld_d2 &&
                        ((r_occ == 3'd0) || ((r_occ == 3'd1) && w_pop));

  always_comb begin
    w_next     = r_state;
    rd_en      = 1'b0;
    rd_address = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = RD_CNT;
      end
      RD_CNT: begin
        rd_en  = 1'b1;
        busy   = 1'b1;
        w_next = WAIT_CNT;
      end
      WAIT_CNT: begin
        busy = 1'b1;
        if (w_cnt_sample) w_next = (w_cnt == '0) ? FINISH : STREAM;
      end
      STREAM: begin
        busy = 1'b1;
        if (w_issue) begin
          rd_en      = 1'b1;
          rd_address = r_rd_ptr[ADDR_WIDTH-1:0];
        end
        if (w_stream_end) w_next = FINISH;
      end
      FINISH: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_vld_d1 <= 1'b0;
      r_vld_d2 <= 1'b0;
      r_pid_d1 <= '0;
      r_pid_d2 <= '0;
      r_wr_ptr <= '0;
      r_head   <= '0;
      r_occ    <= '0;
    end else begin
      r_state  <= w_next;
      r_vld_d1 <= rd_en;
      r_vld_d2 <= r_vld_d1;
      r_pid_d1 <= rd_address;
      r_pid_d2 <= r_pid_d1;
      if ((r_state == IDLE) && start) r_ovf <= 1'b0;
      if (w_cnt_sample) begin
        r_count  <= w_cnt;
        r_ovf    <= w_cnt_ovf;
        r_rd_ptr <= PW'(1);
      end else if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_head   <= r_head + 2'd1;
      r_occ <= r_occ + {2'b00, w_push} - {2'b00, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= rd_q;
      r_fifo_pid[r_wr_ptr]  <= r_pid_d2;
    end
  end

  assign out_valid      = (r_occ != 3'd0);
  assign out_data       = out_valid ? r_fifo_data[r_head] : '0;
  assign out_pid        = out_valid ? r_fifo_pid[r_head]  : '0;
  assign particle_count = r_count;
  assign count_ovf      = r_ovf;

endmodule
`default_nettype wire
